// File: rtl/multicycle_controller_pkg.sv
// ctrl_pkg: shared types and encodings for the multi-cycle RV64I control FSM.
//   state_e  : controller states
//   iclass_e : instruction classes recognised by the opcode decoder
//   OP_*     : base-ISA major opcodes (instruction[6:0])
//   ALU_*, WB_*, PC_* : encodings driven onto alu_op, wb_sel and pc_src
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_R      = 3'd0,
    CL_I      = 3'd1,
    CL_LOAD   = 3'd2,
    CL_STORE  = 3'd3,
    CL_BRANCH = 3'd4,
    CL_JAL    = 3'd5,
    CL_JALR   = 3'd6,
    CL_LUI    = 3'd7
  } iclass_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_MEM    = 2'b01;
  localparam logic [1:0] WB_PC4    = 2'b10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_IMM    = 2'b01;
  localparam logic [1:0] PC_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: datapath/memory handshake bundle between the
// control FSM and the rest of the multi-cycle core.
//   Inputs to the controller : run, opcode, branch_taken, imem_ready, dmem_ready
//   Outputs of the controller: imem_req, ir_write, dmem_req, dmem_we, alu_src_b,
//                              alu_op, reg_write, wb_sel, pc_write, pc_src,
//                              instr_done, trap
//   master modport = controller side, slave modport = datapath side.
interface multicycle_controller_if;
  logic       run;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       imem_ready;
  logic       dmem_ready;
  logic       imem_req;
  logic       ir_write;
  logic       dmem_req;
  logic       dmem_we;
  logic       alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       trap;

  modport master (
    input  run, opcode, branch_taken, imem_ready, dmem_ready,
    output imem_req, ir_write, dmem_req, dmem_we, alu_src_b, alu_op,
           reg_write, wb_sel, pc_write, pc_src, instr_done, trap
  );

  modport slave (
    output run, opcode, branch_taken, imem_ready, dmem_ready,
    input  imem_req, ir_write, dmem_req, dmem_we, alu_src_b, alu_op,
           reg_write, wb_sel, pc_write, pc_src, instr_done, trap
  );
endinterface

// File: rtl/multicycle_controller_decoder.sv
// opcode_class_decoder: combinational map from instruction[6:0] to an
// instruction class, flagging any opcode outside the supported set.
//   opcode_i  : major opcode
//   class_o   : instruction class (CL_R when illegal)
//   illegal_o : 1 when the opcode is not supported
module opcode_class_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output iclass_e    class_o,
  output logic       illegal_o
);

  // Opcode lookup table
  always_comb begin
    class_o   = CL_R;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_R:      class_o = CL_R;
      OP_I:      class_o = CL_I;
      OP_LOAD:   class_o = CL_LOAD;
      OP_STORE:  class_o = CL_STORE;
      OP_BRANCH: class_o = CL_BRANCH;
      OP_JAL:    class_o = CL_JAL;
      OP_JALR:   class_o = CL_JALR;
      OP_LUI:    class_o = CL_LUI;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM sequencing the multi-cycle RV64I datapath
// through FETCH/DECODE/EXEC/MEM/WB, with a sticky TRAP on illegal opcodes.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; forces every output low at once
//   bus   : master side of multicycle_controller_if (memory handshakes,
//           ALU steering, write strobes, instr_done, trap)
// Outputs are decoded from state; ir_write, MEM-state retire strobes and the
// branch pc_src are additionally qualified by their input condition.
module multicycle_controller
  import ctrl_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  multicycle_controller_if.master bus
);

  state_e     state_q, state_d;
  logic [6:0] op_q, op_d;
  // Remembers that an instruction fetch has been issued so the request is
  // held even if run drops before imem_ready.
  logic       fetch_busy_q, fetch_busy_d;

  logic [6:0] dec_in_s;
  iclass_e    cls_s;
  logic       illegal_s;

  logic       imem_req_s, ir_write_s, dmem_req_s, dmem_we_s, alu_src_b_s;
  logic [1:0] alu_op_s, wb_sel_s, pc_src_s;
  logic       reg_write_s, pc_write_s, instr_done_s, trap_s;

  // In DECODE the live IR opcode is classified; afterwards the latched copy.
  assign dec_in_s = (state_q == ST_DECODE) ? bus.opcode : op_q;

  opcode_class_decoder u_dec (
    .opcode_i  (dec_in_s),
    .class_o   (cls_s),
    .illegal_o (illegal_s)
  );

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    fetch_busy_d = fetch_busy_q;
    imem_req_s   = 1'b0;
    ir_write_s   = 1'b0;
    dmem_req_s   = 1'b0;
    dmem_we_s    = 1'b0;
    alu_src_b_s  = 1'b0;
    alu_op_s     = ALU_ADD;
    reg_write_s  = 1'b0;
    wb_sel_s     = WB_ALU;
    pc_write_s   = 1'b0;
    pc_src_s     = PC_PLUS4;
    instr_done_s = 1'b0;
    trap_s       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_s = bus.run | fetch_busy_q;
        if (imem_req_s && bus.imem_ready) begin
          ir_write_s   = 1'b1;
          fetch_busy_d = 1'b0;
          state_d      = ST_DECODE;
        end else begin
          fetch_busy_d = imem_req_s;
        end
      end
      ST_DECODE: begin
        op_d = bus.opcode;
        if (illegal_s) begin
          state_d = ST_TRAP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_WB;
        case (cls_s)
          CL_R: begin
            alu_op_s = ALU_FUNCT;
          end
          CL_I: begin
            alu_op_s    = ALU_FUNCT;
            alu_src_b_s = 1'b1;
          end
          CL_LOAD, CL_STORE: begin
            alu_src_b_s = 1'b1;
            state_d     = ST_MEM;
          end
          CL_JALR, CL_LUI: begin
            alu_src_b_s = 1'b1;
          end
          CL_JAL: begin
            alu_op_s = ALU_ADD;
          end
          CL_BRANCH: begin
            // Branches retire here: compare result picks the next PC.
            alu_op_s     = ALU_SUB;
            pc_write_s   = 1'b1;
            instr_done_s = 1'b1;
            pc_src_s     = bus.branch_taken ? PC_IMM : PC_PLUS4;
            state_d      = ST_FETCH;
          end
          default: begin
            state_d = ST_TRAP;
          end
        endcase
      end
      ST_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = (cls_s == CL_STORE);
        if (bus.dmem_ready) begin
          if (cls_s == CL_STORE) begin
            // Stores have nothing to write back and retire on completion.
            pc_write_s   = 1'b1;
            instr_done_s = 1'b1;
            state_d      = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        reg_write_s  = 1'b1;
        pc_write_s   = 1'b1;
        instr_done_s = 1'b1;
        state_d      = ST_FETCH;
        case (cls_s)
          CL_LOAD: wb_sel_s = WB_MEM;
          CL_JAL: begin
            wb_sel_s = WB_PC4;
            pc_src_s = PC_IMM;
          end
          CL_JALR: begin
            wb_sel_s = WB_PC4;
            pc_src_s = PC_ALU;
          end
          default: wb_sel_s = WB_ALU;
        endcase
      end
      ST_TRAP: begin
        trap_s  = 1'b1;
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase
  end

  // State, latched opcode and fetch-in-flight flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      op_q         <= 7'd0;
      fetch_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      fetch_busy_q <= fetch_busy_d;
    end
  end

  // Reset gates the outputs directly so an in-flight request drops with rst_n,
  // not at the next clock edge.
  assign bus.imem_req   = rst_n & imem_req_s;
  assign bus.ir_write   = rst_n & ir_write_s;
  assign bus.dmem_req   = rst_n & dmem_req_s;
  assign bus.dmem_we    = rst_n & dmem_we_s;
  assign bus.alu_src_b  = rst_n & alu_src_b_s;
  assign bus.alu_op     = {2{rst_n}} & alu_op_s;
  assign bus.reg_write  = rst_n & reg_write_s;
  assign bus.wb_sel     = {2{rst_n}} & wb_sel_s;
  assign bus.pc_write   = rst_n & pc_write_s;
  assign bus.pc_src     = {2{rst_n}} & pc_src_s;
  assign bus.instr_done = rst_n & instr_done_s;
  assign bus.trap       = rst_n & trap_s;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM that sequences the multi-cycle RV64I datapath: it issues instruction fetches to instruction memory, loads the instruction register, steers ALU operands, and issues data-memory transactions. It also produces register-file and PC write strobes. It sits beside the fetch/PC/immediate-generation logic and replaces the free-running "PC loads every clock" behaviour with one PC update per retired instruction. Both memories are variable-latency through a req/ready handshake.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- run  in  1  permits a new fetch; sampled only in FETCH before a request starts
- opcode  in  7  instruction[6:0] from the datapath IR; valid from DECODE onward
- branch_taken  in  1  selected ALU flag for the current branch; valid in EXEC
- imem_ready  in  1  instruction memory has data this cycle
- dmem_ready  in  1  data memory completed the access this cycle
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load IR from memory output
- dmem_req  out  1  data memory request
- dmem_we  out  1  data request is a store
- alu_src_b  out  1  0 = rs2, 1 = immediate
- alu_op  out  2  00 add, 01 subtract/compare, 10 funct-decoded
- reg_write  out  1  register-file write strobe
- wb_sel  out  2  00 ALU, 01 memory, 10 PC+4
- pc_write  out  1  PC load strobe
- pc_src  out  2  00 PC+4, 01 PC+imm, 10 ALU result
- instr_done  out  1  one-cycle pulse when an instruction retires
- trap  out  1  illegal opcode seen; sticky until reset

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH
  - imem_req = run, or held at 1 once a request has started.
  - A request, once raised, stays high until imem_ready, even if run falls.
  - On imem_ready: ir_write = 1, then go to DECODE.
- DECODE
  - Latch opcode into op_q and classify it.
  - Classes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
  - Any other opcode goes to TRAP.
- EXEC
  - R: alu_op 10, alu_src_b 0.
  - I: alu_op 10, alu_src_b 1.
  - LOAD/STORE/JALR/LUI: alu_op 00, alu_src_b 1.
  - BRANCH: alu_op 01, alu_src_b 0; assert pc_write and instr_done; pc_src = branch_taken ? 01 : 00; then go to FETCH.
  - JAL: alu_op 00.
  - Next state: LOAD/STORE go to MEM; all other classes go to WB.
- MEM
  - dmem_req = 1; dmem_we = 1 for STORE.
  - dmem_req is held until dmem_ready.
  - On dmem_ready, LOAD goes to WB.
  - On dmem_ready, STORE asserts pc_write (pc_src 00) and instr_done, then goes to FETCH.
- WB
  - reg_write = 1 and pc_write = 1 in the same cycle, then go to FETCH.
  - wb_sel: LOAD 01; JAL/JALR 10; all other classes 00.
  - pc_src: JAL 01; JALR 10; all other classes 00.
- TRAP: all strobes 0, trap = 1; the FSM never leaves TRAP except by reset.
- Inactive strobes are 0 in every state; default encodings are 0.

## Timing
- Reset (async, immediate): state FETCH, op_q = 0, and every output 0, including any in-flight imem_req/dmem_req.
- Outputs are Moore on state, except:
  - ir_write is qualified by imem_ready.
  - MEM-state pc_write/instr_done are qualified by dmem_ready.
  - EXEC-state pc_src is qualified by branch_taken.
- Minimum cycles per instruction with zero-wait memories (ready high in the request cycle):
  - BRANCH 3
  - R, I, LUI, JAL, JALR, STORE 4
  - LOAD 5
- Each memory wait cycle adds exactly one cycle. Request outputs stay stable during waits.
- run = 0 in FETCH with no request outstanding: the FSM holds FETCH with all outputs 0.
- imem_ready or dmem_ready outside the matching request is ignored.
- pc_write is asserted exactly once per retired instruction, in the same cycle as instr_done.
- reg_write is never asserted for STORE or BRANCH.
- Reset asserted mid-transaction aborts that transaction with no write strobe.

## Structure
- Package ctrl_pkg holds:
  - state enum
  - opcode constants
  - instruction-class enum
  - alu_op, wb_sel and pc_src encodings
- Sub-module opcode_class_decoder: combinational, opcode[6:0] to class plus an illegal flag.
- The FSM is a single always block for state/op_q, with combinational output decode.

## Test plan
- R-type add, zero-wait memories, run = 1 → FETCH/DECODE/EXEC/WB in 4 cycles; reg_write, wb_sel 00 and pc_write with pc_src 00 in cycle 4; instr_done pulses once.
- LOAD with dmem_ready delayed 2 cycles → dmem_req high 3 cycles, dmem_we 0; WB has wb_sel 01; total 7 cycles.
- BRANCH with branch_taken = 1, then = 0 → 3-cycle retire; pc_src 01 and 00 respectively; reg_write never asserted.
- JALR → EXEC alu_op 00, alu_src_b 1; WB has reg_write, wb_sel 10, pc_src 10.
- Opcode 0000000 → TRAP after DECODE; trap stays 1 and all strobes stay 0 for 20 cycles; rst_n low clears trap.
- rst_n asserted mid-wait in STORE's MEM state → dmem_req drops in the same cycle with no pc_write; after release, FETCH; imem_req rises only once run = 1.
